// File: rtl/antares_pkg.sv
// Shared constants and types for the Antares fetch front end.
package antares_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam word_t PC_STEP           = 32'd4;

    // Sequential successor; wraps modulo 2^32 by plain overflow.
    function automatic word_t pc_inc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_pipe_if.sv
// Hazard-unit / instruction-memory / ID-stage signals of the fetch stage.
interface fetch_pipe_if;
    import antares_pkg::*;

    logic  stallIF;
    logic  ifIdWrite;
    logic  branchTaken;
    word_t branchTarget;
    logic  flushID;
    word_t imemAddr;
    word_t imemData;
    word_t instrID;
    word_t pcID;
    logic  validID;
    word_t stallCount;

    // Control and memory sources: hazard unit, branch resolver, imem model.
    modport master (
        output stallIF, ifIdWrite, branchTaken, branchTarget, flushID, imemData,
        input  imemAddr, instrID, pcID, validID, stallCount
    );

    modport slave (
        input  stallIF, ifIdWrite, branchTaken, branchTarget, flushID, imemData,
        output imemAddr, instrID, pcID, validID, stallCount
    );

endinterface

// File: rtl/fetch_pipe_pc_unit.sv
// Program counter register with redirect / advance / hold next-PC selection.
module pc_unit
    import antares_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  advance,
    input  logic  redirect,
    input  word_t target,
    output word_t pc,
    output word_t pc_next_seq
);

    assign pc_next_seq = pc_inc(pc);

    // Redirect wins over advance; the target is taken verbatim, low bits included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc_next_seq;
        end
    end

endmodule

// File: rtl/fetch_pipe.sv
// Instruction fetch stage: PC unit plus IF/ID pipeline register.
// Optional stall-cycle counter enabled by defining FETCH_STALL_COUNTER_EN.
module fetch_pipe
    import antares_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    fetch_pipe_if.slave bus
);

    word_t pc;
    word_t pc_plus4;
    word_t instr_q;
    word_t pc_id_q;
    logic  valid_q;
    logic  squash;

    assign squash = bus.branchTaken | bus.flushID;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (bus.stallIF),
        .redirect    (bus.branchTaken),
        .target      (bus.branchTarget),
        .pc          (pc),
        .pc_next_seq (pc_plus4)
    );

    assign bus.imemAddr = pc;

    // Squash outranks ifIdWrite so a flush still lands during a hazard stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_id_q <= '0;
            valid_q <= 1'b0;
        end else if (squash) begin
            instr_q <= NOP_INSTR;
            pc_id_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.ifIdWrite) begin
            instr_q <= bus.imemData;
            pc_id_q <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

    assign bus.instrID = instr_q;
    assign bus.pcID    = pc_id_q;
    assign bus.validID = valid_q;

`ifdef FETCH_STALL_COUNTER_EN
    word_t stall_count_q;

    // Counts held IF/ID cycles that were not squashed; saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (!squash && !bus.ifIdWrite && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign bus.stallCount = stall_count_q;
`else
    assign bus.stallCount = '0;
`endif

endmodule

// File: tb/tb_fetch_pipe.sv
// Self-checking bench for fetch_pipe: vector table, corner sequences, random vs reference model.
module tb_fetch_pipe;
    import antares_pkg::*;

`ifdef FETCH_STALL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam word_t NOP = 32'h0000_0000;

    typedef struct {
        logic  stall;
        logic  write;
        logic  br;
        logic  fl;
        word_t tgt;
        word_t e_pc;
        word_t e_pcid;
        logic  e_valid;
        word_t e_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    fetch_pipe_if bus ();

    fetch_pipe #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: arbitrary address-dependent contents.
    function automatic word_t imem(input word_t a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.imemData = imem(bus.imemAddr);

    int    n_vec = 0;
    int    n_err = 0;
    vec_t  tbl[$];

    // Reference model state
    word_t m_pc;
    word_t m_instr;
    word_t m_pcid;
    logic  m_valid;
    word_t m_cnt;

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = NOP;
        m_pcid  = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".imemAddr"}, bus.imemAddr, m_pc);
        chk({tag, ".instrID"}, bus.instrID, m_instr);
        chk({tag, ".pcID"}, bus.pcID, m_pcid);
        chk({tag, ".validID"}, {31'b0, bus.validID}, {31'b0, m_valid});
        chk({tag, ".stallCount"}, bus.stallCount, CNT_EN ? m_cnt : 32'h0);
    endtask

    // Driver: apply one cycle of controls, advance one edge, update the model.
    task automatic drive_edge(input logic s, input logic w, input logic b,
                              input word_t t, input logic f);
        word_t cur_pc;
        bus.stallIF      = s;
        bus.ifIdWrite    = w;
        bus.branchTaken  = b;
        bus.branchTarget = t;
        bus.flushID      = f;
        cur_pc = m_pc;
        @(posedge clk);
        #1;
        if (b || f) begin
            m_instr = NOP;
            m_pcid  = 32'h0;
            m_valid = 1'b0;
        end else if (w) begin
            m_instr = imem(cur_pc);
            m_pcid  = cur_pc + 32'd4;
            m_valid = 1'b1;
        end else if (m_cnt != 32'hFFFF_FFFF) begin
            m_cnt = m_cnt + 32'd1;
        end
        if (b)      m_pc = t;
        else if (s) m_pc = cur_pc + 32'd4;
    endtask

    task automatic add_vec(input logic s, input logic w, input logic b, input logic f,
                           input word_t t, input word_t ep, input word_t epid,
                           input logic ev, input word_t ec);
        vec_t v;
        v.stall = s; v.write = w; v.br = b; v.fl = f; v.tgt = t;
        v.e_pc = ep; v.e_pcid = epid; v.e_valid = ev; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.stallIF      = 1'b1;
        bus.ifIdWrite    = 1'b1;
        bus.branchTaken  = 1'b0;
        bus.branchTarget = 32'h0;
        bus.flushID      = 1'b0;
        model_reset();

        // Expected values assume the counter is enabled; masked to 0 otherwise.
        add_vec(1, 1, 0, 0, 32'h0,         32'h4,         32'h4,         1, 0);
        add_vec(1, 1, 0, 0, 32'h0,         32'h8,         32'h8,         1, 0);
        add_vec(1, 1, 0, 0, 32'h0,         32'hC,         32'hC,         1, 0);
        add_vec(1, 1, 1, 0, 32'h4,         32'h4,         32'h0,         0, 0);
        add_vec(1, 1, 0, 0, 32'h0,         32'h8,         32'h8,         1, 0);
        add_vec(0, 0, 0, 0, 32'h0,         32'h8,         32'h8,         1, 1);
        add_vec(0, 0, 1, 0, 32'h40,        32'h40,        32'h0,         0, 1);
        add_vec(1, 1, 0, 0, 32'h0,         32'h44,        32'h44,        1, 1);
        add_vec(0, 0, 0, 1, 32'h0,         32'h44,        32'h0,         0, 1);
        add_vec(1, 0, 0, 0, 32'h0,         32'h48,        32'h0,         0, 2);
        add_vec(1, 1, 1, 0, 32'h100,       32'h100,       32'h0,         0, 2);
        add_vec(1, 1, 1, 0, 32'h203,       32'h203,       32'h0,         0, 2);
        add_vec(1, 1, 0, 0, 32'h0,         32'h207,       32'h207,       1, 2);
        add_vec(1, 1, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         0, 2);
        add_vec(1, 1, 0, 0, 32'h0,         32'h0,         32'h0,         1, 2);
        add_vec(1, 1, 0, 0, 32'h0,         32'h4,         32'h4,         1, 2);

        // Reset state while held, with clock running
        #12;
        chk("reset.imemAddr", bus.imemAddr, 32'h0);
        chk("reset.instrID", bus.instrID, NOP);
        chk("reset.pcID", bus.pcID, 32'h0);
        chk("reset.validID", {31'b0, bus.validID}, 32'h0);
        chk("reset.stallCount", bus.stallCount, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (tbl[i]) begin
            drive_edge(tbl[i].stall, tbl[i].write, tbl[i].br, tbl[i].tgt, tbl[i].fl);
            chk($sformatf("vec%0d.imemAddr", i), bus.imemAddr, tbl[i].e_pc);
            chk($sformatf("vec%0d.pcID", i), bus.pcID, tbl[i].e_pcid);
            chk($sformatf("vec%0d.validID", i), {31'b0, bus.validID}, {31'b0, tbl[i].e_valid});
            chk($sformatf("vec%0d.instrID", i), bus.instrID,
                tbl[i].e_valid ? imem(tbl[i].e_pcid - 32'd4) : NOP);
            chk($sformatf("vec%0d.stallCount", i), bus.stallCount, CNT_EN ? tbl[i].e_cnt : 32'h0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic  s, w, b, f;
            word_t t;
            s = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFF8;
                1:       t = $urandom;
                default: t = $urandom & 32'h0000_FFFC;
            endcase
            drive_edge(s, w, b, t, f);
            chk_model($sformatf("rnd%0d", i));
        end

`ifdef FETCH_STALL_COUNTER_EN
        // Saturation: preload near the top, then hold IF/ID
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        m_cnt = 32'hFFFF_FFFE;
        drive_edge(0, 0, 0, 32'h0, 0);
        chk_model("sat0");
        drive_edge(0, 0, 0, 32'h0, 0);
        chk_model("sat1");
        drive_edge(1, 0, 0, 32'h0, 0);
        chk_model("sat2");
`endif

        // Asynchronous reset mid-stall, then resume from RESET_PC
        drive_edge(1, 1, 0, 32'h0, 0);
        drive_edge(0, 0, 0, 32'h0, 0);
        chk_model("pre_areset");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_model("areset");
        @(negedge clk);
        chk_model("areset_hold");
        rst_n = 1'b1;
        drive_edge(1, 1, 0, 32'h0, 0);
        chk_model("post_reset0");
        chk("post_reset0.validID_set", {31'b0, bus.validID}, 32'h1);
        drive_edge(1, 1, 0, 32'h0, 0);
        chk_model("post_reset1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pipe.md
FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted as a bubble.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stallIF  input  1  from hazard unit; 1 = PC advances, 0 = PC holds.
REQ-006 ifIdWrite  input  1  from hazard unit; 1 = IF/ID register loads, 0 = holds.
REQ-007 branchTaken  input  1  branch/jump resolved taken in ID; redirect PC, squash IF/ID.
REQ-008 branchTarget  input  32  redirect address, valid when branchTaken=1.
REQ-009 flushID  input  1  external squash of IF/ID contents (exception/flush request).
REQ-010 imemAddr  output  32  instruction memory address (current PC).
REQ-011 imemData  input  32  instruction word, combinational read of imemAddr.
REQ-012 instrID  output  32  registered instruction for ID stage.
REQ-013 pcID  output  32  registered PC+4 of instrID.
REQ-014 validID  output  1  1 = instrID is a real instruction, 0 = bubble.
REQ-015 stallCount  output  32  stall-cycle counter (see Configuration).

Function
REQ-016 imemAddr SHALL equal the PC register combinationally.
REQ-017 PC update priority per edge: branchTaken -> PC=branchTarget; else stallIF=1 -> PC=PC+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0); else hold.
REQ-018 IF/ID update priority per edge: branchTaken or flushID -> instrID=NOP_INSTR, pcID=0, validID=0; else ifIdWrite=1 -> instrID=imemData, pcID=PC+4, validID=1; else hold all three.
REQ-019 Flush SHALL override ifIdWrite=0 (squash during hazard stall).
REQ-020 Fetch-to-ID latency SHALL be exactly one cycle; no combinational path from imemData to ID outputs.
REQ-021 stallIF=1 with ifIdWrite=0 SHALL be executed literally (PC advances, IF/ID holds); the hazard unit never drives this pair, it is not corrected here.
REQ-022 branchTaken asserted on consecutive cycles SHALL redirect on each cycle; last target wins.
REQ-023 branchTarget bits [1:0] SHALL be loaded unchanged; alignment is the producer's responsibility.

Reset
REQ-024 While rst_n=0: PC=RESET_PC, instrID=NOP_INSTR, pcID=0, validID=0, stallCount=0, regardless of clk.
REQ-025 Reset deassertion mid-stall SHALL resume from RESET_PC; first valid instruction appears on instrID one edge after release.

Configuration
REQ-026 Macro FETCH_STALL_COUNTER_EN defined: stallCount increments by 1 on each edge with ifIdWrite=0 and no branchTaken/flushID; saturates at 32'hFFFF_FFFF.
REQ-027 Macro undefined: stallCount port SHALL remain present and be driven constant 0; no counter register synthesized.

Structure
REQ-028 Shared package antares_pkg SHALL hold XLEN=32, NOP_INSTR default, RESET_PC default, PC_STEP=4.
REQ-029 PC register plus next-PC mux SHALL be sub-module pc_unit; IF/ID register and counter remain in fetch_pipe.

Verification
REQ-030 Reset: rst_n=0 asynchronously mid-cycle -> imemAddr=0, instrID=0, validID=0 immediately.
REQ-031 Sequential fetch: stallIF=1, ifIdWrite=1, 3 edges from PC=0 -> imemAddr 4,8,12; pcID 4,8,12; validID=1.
REQ-032 Load-use stall: at PC=8 drive stallIF=0, ifIdWrite=0 one cycle -> PC stays 8, instrID/pcID unchanged, stallCount +1 (macro on) or 0 (off).
REQ-033 Branch during stall: stallIF=0, ifIdWrite=0, branchTaken=1, branchTarget=32'h40 -> PC=32'h40, validID=0, instrID=NOP_INSTR, stallCount unchanged.
REQ-034 Wrap: PC=32'hFFFF_FFFC, stallIF=1 -> PC=0, pcID=0, validID=1.
REQ-035 Saturation (macro on): preload stallCount=32'hFFFF_FFFF, hold ifIdWrite=0 -> stays 32'hFFFF_FFFF.
